// File: rtl/gelu_shared_lut_server.sv
// rtl/gelu_shared_lut_server.sv - shared GELU PWL coefficient table server, optional stats via SHARED_LUT_STATS_EN
module gelu_shared_lut_server #(
  parameter int NUM_PORTS  = 8,
  parameter int W          = 64,
  parameter int SEG_BITS   = 3,
  parameter int NUM_SEG    = 8,
  parameter int RD_PER_CYC = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [SEG_BITS-1:0]           cfg_addr,
  input  logic [W-1:0]                  cfg_k,
  input  logic [W-1:0]                  cfg_b,
  output logic                          lut_ready,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*SEG_BITS-1:0] req_seg,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  output logic [NUM_PORTS*W-1:0]        rsp_k,
  output logic [NUM_PORTS*W-1:0]        rsp_b,
`ifdef SHARED_LUT_STATS_EN
  output logic [NUM_PORTS*32-1:0]       stat_grants,
  output logic [31:0]                   stat_stalls,
`endif
  output logic                          seg_err
);
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH = 1 << SEG_BITS;

  typedef enum logic {S_UNINIT, S_READY} state_t;

  state_t                r_state;
  logic [NUM_SEG-1:0]    r_mask;
  logic [PW-1:0]         r_ptr;
  logic                  r_seg_err;
  logic [W-1:0]          r_tab_k [DEPTH];
  logic [W-1:0]          r_tab_b [DEPTH];

  logic [RD_PER_CYC-1:0] r_s1_vld, r_s2_vld;
  logic [PW-1:0]         r_s1_port [RD_PER_CYC];
  logic [PW-1:0]         r_s2_port [RD_PER_CYC];
  logic [W-1:0]          r_s1_k [RD_PER_CYC];
  logic [W-1:0]          r_s1_b [RD_PER_CYC];
  logic [W-1:0]          r_s2_k [RD_PER_CYC];
  logic [W-1:0]          r_s2_b [RD_PER_CYC];
  logic [NUM_PORTS-1:0]  r_rsp_valid;
  logic [NUM_PORTS*W-1:0] r_rsp_k, r_rsp_b;

  logic [NUM_PORTS-1:0]  w_grant;
  logic                  w_any;
  logic [PW-1:0]         w_last;
  logic                  w_bad_seg;
  logic [RD_PER_CYC-1:0] w_slot_vld;
  logic [PW-1:0]         w_slot_port [RD_PER_CYC];
  logic [W-1:0]          w_slot_k [RD_PER_CYC];
  logic [W-1:0]          w_slot_b [RD_PER_CYC];
  logic                  w_cfg_hit;
  logic [NUM_SEG-1:0]    w_mask_nx;

  assign w_cfg_hit = cfg_we && (int'(cfg_addr) < NUM_SEG);
  assign lut_ready = (r_state == S_READY);
  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_k     = r_rsp_k;
  assign rsp_b     = r_rsp_b;
  assign seg_err   = r_seg_err;

  // Written-mask including the write landing at this edge
  always_comb begin
    w_mask_nx = r_mask;
    if (w_cfg_hit) w_mask_nx[cfg_addr] = 1'b1;
  end

  // Round-robin scan from r_ptr, first RD_PER_CYC valid ports win a read slot.
  // The table is read here, before the edge, so a write at the grant edge is not seen.
  always_comb begin
    int n;
    logic [PW-1:0]       idx;
    logic [SEG_BITS-1:0] seg;
    n         = 0;
    idx       = '0;
    seg       = '0;
    w_grant   = '0;
    w_any     = 1'b0;
    w_last    = r_ptr;
    w_bad_seg = 1'b0;
    w_slot_vld = '0;
    for (int s = 0; s < RD_PER_CYC; s++) begin
      w_slot_port[s] = '0;
      w_slot_k[s]    = '0;
      w_slot_b[s]    = '0;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = PW'((int'(r_ptr) + i) % NUM_PORTS);
      seg = req_seg[int'(idx)*SEG_BITS +: SEG_BITS];
      if (r_state == S_READY && req_valid[idx] && n < RD_PER_CYC) begin
        w_grant[idx]   = 1'b1;
        w_any          = 1'b1;
        w_last         = idx;
        w_slot_vld[n]  = 1'b1;
        w_slot_port[n] = idx;
        if (int'(seg) < NUM_SEG) begin
          w_slot_k[n] = r_tab_k[seg];
          w_slot_b[n] = r_tab_b[seg];
        end else begin
          w_bad_seg = 1'b1;
        end
        n++;
      end
    end
  end

  // Coefficient table storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (w_cfg_hit) begin
      r_tab_k[cfg_addr] <= cfg_k;
      r_tab_b[cfg_addr] <= cfg_b;
    end
  end

  // Load-tracking FSM, RR pointer and sticky segment error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_UNINIT;
      r_mask    <= '0;
      r_ptr     <= '0;
      r_seg_err <= 1'b0;
    end else begin
      r_mask <= w_mask_nx;
      case (r_state)
        S_UNINIT: if (&w_mask_nx) r_state <= S_READY;
        default:  r_state <= S_READY;
      endcase
      if (w_any) r_ptr <= (w_last == PW'(NUM_PORTS - 1)) ? '0 : w_last + 1'b1;
      if (w_bad_seg) r_seg_err <= 1'b1;
    end
  end

  // Two pipeline stages between grant and response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld <= '0;
      r_s2_vld <= '0;
    end else begin
      r_s1_vld <= w_slot_vld;
      r_s2_vld <= r_s1_vld;
    end
    for (int s = 0; s < RD_PER_CYC; s++) begin
      r_s1_port[s] <= w_slot_port[s];
      r_s1_k[s]    <= w_slot_k[s];
      r_s1_b[s]    <= w_slot_b[s];
      r_s2_port[s] <= r_s1_port[s];
      r_s2_k[s]    <= r_s1_k[s];
      r_s2_b[s]    <= r_s1_b[s];
    end
  end

  // Per-port response strobe with held coefficients
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_k     <= '0;
      r_rsp_b     <= '0;
    end else begin
      r_rsp_valid <= '0;
      for (int s = 0; s < RD_PER_CYC; s++) begin
        if (r_s2_vld[s]) begin
          r_rsp_valid[r_s2_port[s]]             <= 1'b1;
          r_rsp_k[int'(r_s2_port[s])*W +: W]    <= r_s2_k[s];
          r_rsp_b[int'(r_s2_port[s])*W +: W]    <= r_s2_b[s];
        end
      end
    end
  end

`ifdef SHARED_LUT_STATS_EN
  logic [NUM_PORTS*32-1:0] r_stat_grants;
  logic [31:0]             r_stat_stalls;
  assign stat_grants = r_stat_grants;
  assign stat_stalls = r_stat_stalls;

  // Saturating grant and stall counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_grants <= '0;
      r_stat_stalls <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_grant[p] && r_stat_grants[p*32 +: 32] != 32'hFFFF_FFFF)
          r_stat_grants[p*32 +: 32] <= r_stat_grants[p*32 +: 32] + 32'd1;
      end
      if (r_state == S_READY && |(req_valid & ~w_grant) && r_stat_stalls != 32'hFFFF_FFFF)
        r_stat_stalls <= r_stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gelu_shared_lut_server.sv
// tb/tb_gelu_shared_lut_server.sv - scoreboard bench for gelu_shared_lut_server
module tb_gelu_shared_lut_server;
  logic         clk, rst_n;
  logic         cfg_we;
  logic [2:0]   cfg_addr;
  logic [63:0]  cfg_k, cfg_b;
  logic         lut_ready, seg_err;
  logic [7:0]   req_valid, req_ready, rsp_valid;
  logic [23:0]  req_seg;
  logic [511:0] rsp_k, rsp_b;

  logic         cfg_we6;
  logic [2:0]   cfg_addr6;
  logic [63:0]  cfg_k6, cfg_b6;
  logic         lut_ready6, seg_err6;
  logic [7:0]   req_valid6, req_ready6, rsp_valid6;
  logic [23:0]  req_seg6;
  logic [511:0] rsp_k6, rsp_b6;
`ifdef SHARED_LUT_STATS_EN
  logic [255:0] stat_grants, stat_grants6;
  logic [31:0]  stat_stalls, stat_stalls6;
`endif

  gelu_shared_lut_server dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_k(cfg_k), .cfg_b(cfg_b),
    .lut_ready(lut_ready), .req_valid(req_valid), .req_seg(req_seg), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_k(rsp_k), .rsp_b(rsp_b),
`ifdef SHARED_LUT_STATS_EN
    .stat_grants(stat_grants), .stat_stalls(stat_stalls),
`endif
    .seg_err(seg_err)
  );

  gelu_shared_lut_server #(.NUM_SEG(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we6), .cfg_addr(cfg_addr6), .cfg_k(cfg_k6), .cfg_b(cfg_b6),
    .lut_ready(lut_ready6), .req_valid(req_valid6), .req_seg(req_seg6), .req_ready(req_ready6),
    .rsp_valid(rsp_valid6), .rsp_k(rsp_k6), .rsp_b(rsp_b6),
`ifdef SHARED_LUT_STATS_EN
    .stat_grants(stat_grants6), .stat_stalls(stat_stalls6),
`endif
    .seg_err(seg_err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          port;
    logic [63:0] k;
    logic [63:0] b;
  } exp_t;

  exp_t        q[$];
  logic [63:0] m_k [8];
  logic [63:0] m_b [8];
  logic [7:0]  m_mask;
  logic        m_ready;
  int          m_ptr;
  int          cyc;
  int          total, bad;
  logic [7:0]  obs_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: predict grants, push expected responses, then check outputs after the edge
  task automatic step();
    logic [7:0] g, ev;
    int         n, last, idx;
    logic [2:0] sg;
    exp_t       e;
    #1;
    g = '0; n = 0; last = -1;
    if (m_ready) begin
      for (int i = 0; i < 8; i++) begin
        idx = (m_ptr + i) % 8;
        if (req_valid[idx] && n < 2) begin
          g[idx] = 1'b1; n++; last = idx;
          sg = req_seg[idx*3 +: 3];
          e.due = cyc + 3; e.port = idx; e.k = m_k[sg]; e.b = m_b[sg];
          q.push_back(e);
        end
      end
    end
    obs_ready = req_ready;
    chk("req_ready", {56'b0, req_ready}, {56'b0, g});
    if (last >= 0) m_ptr = (last + 1) % 8;
    if (cfg_we) begin
      m_k[cfg_addr] = cfg_k; m_b[cfg_addr] = cfg_b; m_mask[cfg_addr] = 1'b1;
    end
    if (m_mask == 8'hFF) m_ready = 1'b1;
    if (!rst_n) begin
      q.delete(); m_ptr = 0; m_mask = '0; m_ready = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
    ev = '0;
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      ev[e.port] = 1'b1;
      chk("rsp_k", rsp_k[e.port*64 +: 64], e.k);
      chk("rsp_b", rsp_b[e.port*64 +: 64], e.b);
    end
    chk("rsp_valid", {56'b0, rsp_valid}, {56'b0, ev});
    chk("lut_ready", {63'b0, lut_ready}, {63'b0, m_ready});
    chk("seg_err", {63'b0, seg_err}, 64'd0);
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [63:0] k, input logic [63:0] b);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_k = k; cfg_b = b;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wr6(input int a, input logic [63:0] k, input logic [63:0] b);
    cfg_we6 = 1'b1; cfg_addr6 = 3'(a); cfg_k6 = k; cfg_b6 = b;
    step();
    cfg_we6 = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    total = 0; bad = 0; cyc = 0; m_ptr = 0; m_mask = '0; m_ready = 1'b0;
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_k = '0; cfg_b = '0; req_valid = '0; req_seg = '0;
    cfg_we6 = 1'b0; cfg_addr6 = '0; cfg_k6 = '0; cfg_b6 = '0; req_valid6 = '0; req_seg6 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_lut_ready", {63'b0, lut_ready}, 64'd0);
    chk("rst_rsp_valid", {56'b0, rsp_valid}, 64'd0);
    chk("rst_rsp_k", {63'b0, |rsp_k}, 64'd0);
    chk("rst_rsp_b", {63'b0, |rsp_b}, 64'd0);
    chk("rst_seg_err", {63'b0, seg_err}, 64'd0);

    // Load 0..6 with every port requesting: nothing may be granted
    for (int p = 0; p < 8; p++) req_seg[p*3 +: 3] = 3'(p);
    req_valid = 8'hFF;
    for (int a = 0; a < 7; a++) wr(a, {$urandom, $urandom}, {$urandom, $urandom});
    chk("not_ready_before_7", {63'b0, lut_ready}, 64'd0);
    wr(7, {$urandom, $urandom}, {$urandom, $urandom});
    chk("ready_after_7", {63'b0, lut_ready}, 64'd1);

    // Continuous requests from all ports: pairs rotate from ptr 0
    for (int i = 0; i < 10; i++) begin
      step();
      pat = 8'h03 << (2 * (i % 4));
      chk("rr_pair", {56'b0, obs_ready}, {56'b0, pat});
    end
    req_valid = '0;
    repeat (4) step();

    // Single lookup of a known entry
    wr(3, 64'h0000_0000_0001_8000, 64'h0000_0000_0000_4000);
    req_valid = 8'h20; req_seg[15 +: 3] = 3'd3;
    step();
    req_valid = '0;
    repeat (3) step();
    chk("p5_k_held", rsp_k[5*64 +: 64], 64'h0000_0000_0001_8000);
    chk("p5_b_held", rsp_b[5*64 +: 64], 64'h0000_0000_0000_4000);

    // Write and read of entry 2 on the same edge, then a fresh read
    req_valid = 8'h01; req_seg[0 +: 3] = 3'd2;
    wr(2, 64'h0000_0000_0002_0000, 64'h0000_0000_0000_1234);
    step();
    req_valid = '0;
    repeat (3) step();
    chk("p0_new_k", rsp_k[0 +: 64], 64'h0000_0000_0002_0000);

    // Reset while a lookup is in flight
    req_valid = 8'h02; req_seg[3 +: 3] = 3'd2;
    step();
    req_valid = '0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_ready", {63'b0, lut_ready}, 64'd0);
    chk("post_rst_segerr", {63'b0, seg_err}, 64'd0);
    chk("post_rst_rsp_k", {63'b0, |rsp_k}, 64'd0);

    // Six-entry table: out-of-range write ignored, out-of-range read gives zero and sticky error
    for (int a = 0; a < 5; a++) wr6(a, 64'(a + 1), 64'(a + 100));
    wr6(6, 64'hDEAD, 64'hBEEF);
    chk("n6_ignored_wr", {63'b0, lut_ready6}, 64'd0);
    wr6(5, 64'd6, 64'd105);
    chk("n6_ready", {63'b0, lut_ready6}, 64'd1);
    req_valid6 = 8'h08; req_seg6[9 +: 3] = 3'd2;
    #1 chk("n6_grant_ok", {56'b0, req_ready6}, 64'h08);
    step();
    req_valid6 = '0;
    step();
    step();
    chk("n6_ok_valid", {56'b0, rsp_valid6}, 64'h08);
    chk("n6_ok_k", rsp_k6[3*64 +: 64], 64'd3);
    chk("n6_ok_err", {63'b0, seg_err6}, 64'd0);
    req_valid6 = 8'h08; req_seg6[9 +: 3] = 3'd7;
    #1 chk("n6_grant_bad", {56'b0, req_ready6}, 64'h08);
    step();
    req_valid6 = '0;
    step();
    step();
    chk("n6_bad_valid", {56'b0, rsp_valid6}, 64'h08);
    chk("n6_bad_k", rsp_k6[3*64 +: 64], 64'd0);
    chk("n6_bad_b", rsp_b6[3*64 +: 64], 64'd0);
    chk("n6_err_set", {63'b0, seg_err6}, 64'd1);
    step();
    chk("n6_valid_pulse", {56'b0, rsp_valid6}, 64'd0);
    chk("n6_err_held", {63'b0, seg_err6}, 64'd1);
`ifdef SHARED_LUT_STATS_EN
    chk("n6_stat_grants", {32'b0, stat_grants6[3*32 +: 32]}, 64'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
